// File: rtl/restoring_div_seq.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Divide-by-zero short-circuits straight to DONE with a flagged result.
module restoring_div_seq #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  dvd_q, dvd_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [N:0]    partial_q, partial_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quotient_q, quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          dbz_q, dbz_d;

    logic [N:0]    shifted;
    logic [N:0]    subtrahend;
    logic [N:0]    trial;
    logic [N+1:0]  borrow;
    logic          q_bit;
    logic [N:0]    step_partial;

    // The partial remainder always stays below the divisor, so its top bit
    // only ever holds 0; it is kept so the register matches the datapath width.
    logic unused_partial_msb;
    assign unused_partial_msb = partial_q[N];

    // One restoring step: shift in the next dividend bit, trial-subtract.
    always_comb begin
        shifted    = {partial_q[N-1:0], dvd_q[N-1]};
        subtrahend = {1'b0, dvs_q};
        borrow[0]  = 1'b0;
        for (int i = 0; i <= N; i++) begin
            trial[i]    = shifted[i] ^ subtrahend[i] ^ borrow[i];
            borrow[i+1] = (~shifted[i] & subtrahend[i])
                        | (~(shifted[i] ^ subtrahend[i]) & borrow[i]);
        end
        q_bit        = ~borrow[N+1];
        step_partial = borrow[N+1] ? shifted : trial;
    end

    always_comb begin
        // NOTE: every next-state signal gets a hold default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        partial_d   = partial_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        state_d     = S_DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d   = S_CALC;
                        dvd_d     = dividend;
                        dvs_d     = divisor;
                        partial_d = '0;
                        cnt_d     = '0;
                        dbz_d     = 1'b0;
                    end
                end
            end

            S_CALC: begin
                // Quotient bits fill the dividend register from the bottom as
                // dividend bits leave from the top.
                partial_d = step_partial;
                dvd_d     = {dvd_q[N-2:0], q_bit};
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d     = S_DONE;
                    quotient_d  = {dvd_q[N-2:0], q_bit};
                    remainder_d = step_partial[N-1:0];
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            partial_q   <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            partial_q   <= partial_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == S_CALC);
    assign done        = (state_q == S_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
